// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turns PS/2 set-2 scan code bytes into key-release pulses
// (Ctrl, Enter, decimal digits) and keeps a BCD entry accumulator that is
// snapshotted into 'value' when Enter is released.
// Optional feature macro: PS2_BACKSPACE_EN (Backspace, code 66, removes the
// most recent digit from the accumulator).
module ps2_key_decoder #(
   parameter int NUM_DIGITS = 4,
   parameter int CNT_W      = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [7:0]              Dato_rx,
   input  logic                    rx_done,
   output logic                    ctrl,
   output logic                    ctrl_held,
   output logic                    enter,
   output logic                    dato,
   output logic [3:0]              digit,
   output logic [4*NUM_DIGITS-1:0] value,
   output logic                    value_valid,
   output logic [CNT_W-1:0]        digit_count,
   output logic                    overflow
);

   localparam logic [7:0] CODE_BRK   = 8'hF0;
   localparam logic [7:0] CODE_EXT   = 8'hE0;
   localparam logic [7:0] CODE_CTRL  = 8'h14;
   localparam logic [7:0] CODE_ENTER = 8'h5A;
`ifdef PS2_BACKSPACE_EN
   localparam logic [7:0] CODE_BKSP  = 8'h66;
`endif
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_DIGITS);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BRK     = 2'd1,
      EXT     = 2'd2,
      EXT_BRK = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [4*NUM_DIGITS-1:0] acc_q, acc_d;
   logic [4*NUM_DIGITS-1:0] value_q, value_d;
   logic [3:0]              digit_q, digit_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic                    overflow_q, overflow_d;
   logic                    held_q, held_d;
   logic                    ctrl_q, ctrl_d;
   logic                    enter_q, enter_d;
   logic                    dato_q, dato_d;
   logic [4:0]              digit_map_s;

   // Maps a scan code to {valid, bcd}; valid=0 for non-digit codes.
   function automatic logic [4:0] map_digit(input logic [7:0] code);
      case (code)
         8'h45:   map_digit = 5'h10;
         8'h16:   map_digit = 5'h11;
         8'h1E:   map_digit = 5'h12;
         8'h26:   map_digit = 5'h13;
         8'h25:   map_digit = 5'h14;
         8'h2E:   map_digit = 5'h15;
         8'h36:   map_digit = 5'h16;
         8'h3D:   map_digit = 5'h17;
         8'h3E:   map_digit = 5'h18;
         8'h46:   map_digit = 5'h19;
         default: map_digit = 5'h00;
      endcase
   endfunction

   assign digit_map_s = map_digit(Dato_rx);

   // Next-state and key actions; only a byte leaving BRK/EXT_BRK acts on a key.
   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      value_d    = value_q;
      digit_d    = digit_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      held_d     = held_q;
      ctrl_d     = 1'b0;
      enter_d    = 1'b0;
      dato_d     = 1'b0;
      if (rx_done) begin
         case (state_q)
            IDLE: begin
               if (Dato_rx == CODE_BRK) begin
                  state_d = BRK;
               end else if (Dato_rx == CODE_EXT) begin
                  state_d = EXT;
               end else begin
                  state_d = IDLE;
                  if (Dato_rx == CODE_CTRL) begin
                     held_d = 1'b1;
                  end else begin
                     held_d = held_q;
                  end
               end
            end
            EXT: begin
               if (Dato_rx == CODE_BRK) begin
                  state_d = EXT_BRK;
               end else begin
                  state_d = IDLE;
                  if (Dato_rx == CODE_CTRL) begin
                     held_d = 1'b1;
                  end else begin
                     held_d = held_q;
                  end
               end
            end
            BRK, EXT_BRK: begin
               // Any byte ends the break sequence; repeated F0/E0 fall
               // through as unmapped codes.
               state_d = IDLE;
               if (Dato_rx == CODE_CTRL) begin
                  ctrl_d = 1'b1;
                  held_d = 1'b0;
               end else if (Dato_rx == CODE_ENTER) begin
                  enter_d    = 1'b1;
                  value_d    = acc_q;
                  acc_d      = '0;
                  count_d    = '0;
                  overflow_d = 1'b0;
               end else if ((state_q == BRK) && digit_map_s[4]) begin
                  dato_d  = 1'b1;
                  digit_d = digit_map_s[3:0];
                  if (count_q < CNT_FULL) begin
                     acc_d       = acc_q << 3'd4;
                     acc_d[3:0]  = digit_map_s[3:0];
                     count_d     = count_q + CNT_ONE;
                  end else begin
                     overflow_d = 1'b1;
                  end
`ifdef PS2_BACKSPACE_EN
               end else if ((state_q == BRK) && (Dato_rx == CODE_BKSP)) begin
                  if (count_q != '0) begin
                     acc_d      = acc_q >> 3'd4;
                     count_d    = count_q - CNT_ONE;
                     overflow_d = 1'b0;
                  end else begin
                     acc_d = acc_q;
                  end
`endif
               end else begin
                  acc_d = acc_q;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // State and registered outputs; reset clears everything immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         value_q    <= '0;
         digit_q    <= 4'd0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         held_q     <= 1'b0;
         ctrl_q     <= 1'b0;
         enter_q    <= 1'b0;
         dato_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         value_q    <= value_d;
         digit_q    <= digit_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         held_q     <= held_d;
         ctrl_q     <= ctrl_d;
         enter_q    <= enter_d;
         dato_q     <= dato_d;
      end
   end

   assign ctrl        = ctrl_q;
   assign ctrl_held   = held_q;
   assign enter       = enter_q;
   assign value_valid = enter_q;
   assign dato        = dato_q;
   assign digit       = digit_q;
   assign value       = value_q;
   assign digit_count = count_q;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder (default NUM_DIGITS=4, CNT_W=3).
module tb_ps2_key_decoder;

   logic        clk;
   logic        reset;
   logic [7:0]  Dato_rx;
   logic        rx_done;
   logic        ctrl;
   logic        ctrl_held;
   logic        enter;
   logic        dato;
   logic [3:0]  digit;
   logic [15:0] value;
   logic        value_valid;
   logic [2:0]  digit_count;
   logic        overflow;

   int checks_total;
   int checks_passed;

   ps2_key_decoder #(.NUM_DIGITS(4), .CNT_W(3)) dut (
      .clk         (clk),
      .reset       (reset),
      .Dato_rx     (Dato_rx),
      .rx_done     (rx_done),
      .ctrl        (ctrl),
      .ctrl_held   (ctrl_held),
      .enter       (enter),
      .dato        (dato),
      .digit       (digit),
      .value       (value),
      .value_valid (value_valid),
      .digit_count (digit_count),
      .overflow    (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_total = checks_total + 1;
      assert (obs === exp) begin
         checks_passed = checks_passed + 1;
      end else begin
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Presents one byte for one clock; returns at the negedge after the
   // sampling posedge, when the registered response is visible.
   task automatic send(input logic [7:0] b);
      @(negedge clk);
      Dato_rx = b;
      rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
      Dato_rx = 8'h00;
   endtask

   task automatic release_key(input logic [7:0] b);
      send(8'hF0);
      send(b);
   endtask

   task automatic idle_cycle();
      @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_outs"}, {27'd0, ctrl, ctrl_held, enter, dato, value_valid}, 32'd0);
      check({tag, "_digit"}, {28'd0, digit}, 32'd0);
      check({tag, "_value"}, {16'd0, value}, 32'd0);
      check({tag, "_cnt"}, {29'd0, digit_count}, 32'd0);
      check({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
   endtask

   initial begin
      checks_total  = 0;
      checks_passed = 0;
      reset   = 1'b0;
      rx_done = 1'b0;
      Dato_rx = 8'h00;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b1;
      idle_cycle();

      // Make/break of 1 and 2 then Enter.
      send(8'h16);
      check("make_no_dato", {31'd0, dato}, 32'd0);
      release_key(8'h16);
      check("rel1_dato", {31'd0, dato}, 32'd1);
      check("rel1_digit", {28'd0, digit}, 32'd1);
      check("rel1_cnt", {29'd0, digit_count}, 32'd1);
      idle_cycle();
      check("rel1_dato_1cyc", {31'd0, dato}, 32'd0);
      check("digit_held", {28'd0, digit}, 32'd1);
      send(8'h1E);
      release_key(8'h1E);
      check("rel2_dato", {31'd0, dato}, 32'd1);
      check("rel2_digit", {28'd0, digit}, 32'd2);
      send(8'h5A);
      check("enter_make_nopulse", {31'd0, enter}, 32'd0);
      release_key(8'h5A);
      check("ent12_enter", {31'd0, enter}, 32'd1);
      check("ent12_vv", {31'd0, value_valid}, 32'd1);
      check("ent12_value", {16'd0, value}, 32'h0012);
      check("ent12_cnt", {29'd0, digit_count}, 32'd0);
      idle_cycle();
      check("ent12_1cyc", {30'd0, enter, value_valid}, 32'd0);
      check("value_held", {16'd0, value}, 32'h0012);

      // Overflow: five digits into a four-digit accumulator.
      release_key(8'h16);
      release_key(8'h1E);
      release_key(8'h26);
      release_key(8'h25);
      check("ovf_cnt4", {29'd0, digit_count}, 32'd4);
      check("ovf_not_yet", {31'd0, overflow}, 32'd0);
      release_key(8'h2E);
      check("ovf_set", {31'd0, overflow}, 32'd1);
      check("ovf_dato", {31'd0, dato}, 32'd1);
      check("ovf_digit", {28'd0, digit}, 32'd5);
      check("ovf_cnt_stays", {29'd0, digit_count}, 32'd4);
      idle_cycle();
      check("ovf_sticky", {31'd0, overflow}, 32'd1);
      release_key(8'h5A);
      check("ovf_value", {16'd0, value}, 32'h1234);
      check("ovf_vv", {31'd0, value_valid}, 32'd1);
      check("ovf_cleared", {31'd0, overflow}, 32'd0);

      // Ctrl make/release and extended Enter with an empty accumulator.
      send(8'h14);
      check("ctrl_held_set", {31'd0, ctrl_held}, 32'd1);
      check("ctrl_make_nopulse", {31'd0, ctrl}, 32'd0);
      release_key(8'h14);
      check("ctrl_pulse", {31'd0, ctrl}, 32'd1);
      check("ctrl_held_clr", {31'd0, ctrl_held}, 32'd0);
      idle_cycle();
      check("ctrl_1cyc", {31'd0, ctrl}, 32'd0);
      send(8'hE0);
      send(8'h14);
      check("ext_ctrl_held", {31'd0, ctrl_held}, 32'd1);
      send(8'hE0);
      release_key(8'h14);
      check("ext_ctrl_pulse", {31'd0, ctrl}, 32'd1);
      check("ext_ctrl_held_clr", {31'd0, ctrl_held}, 32'd0);
      send(8'hE0);
      release_key(8'h5A);
      check("kp_enter", {31'd0, enter}, 32'd1);
      check("kp_enter_vv", {31'd0, value_valid}, 32'd1);
      check("kp_enter_zero", {16'd0, value}, 32'h0000);

      // Extended digit code release is not a digit.
      send(8'hE0);
      release_key(8'h16);
      check("ext_digit_ignored", {31'd0, dato}, 32'd0);
      check("ext_digit_cnt", {29'd0, digit_count}, 32'd0);

      // Unmapped release then digit 0.
      release_key(8'h1C);
      check("unmapped_nopulse", {31'd0, dato}, 32'd0);
      release_key(8'h45);
      check("d0_dato", {31'd0, dato}, 32'd1);
      check("d0_digit", {28'd0, digit}, 32'd0);
      check("d0_cnt", {29'd0, digit_count}, 32'd1);

      // Repeated F0: second F0 is the (unmapped) release byte, so 16 is a make.
      send(8'hF0);
      release_key(8'h16);
      check("rep_f0_no_dato", {31'd0, dato}, 32'd0);
      check("rep_f0_cnt", {29'd0, digit_count}, 32'd1);

      // Bytes without rx_done are ignored.
      @(negedge clk);
      Dato_rx = 8'hF0;
      @(negedge clk);
      Dato_rx = 8'h00;
      send(8'h16);
      check("no_strobe_ignored", {31'd0, dato}, 32'd0);
      release_key(8'h5A);
      check("clear_value", {16'd0, value}, 32'h0000);

      // Backspace behaviour depends on the build option.
      release_key(8'h3D);
      release_key(8'h3E);
      release_key(8'h66);
      check("bksp_nopulse", {28'd0, ctrl, enter, dato, value_valid}, 32'd0);
`ifdef PS2_BACKSPACE_EN
      check("bksp_cnt", {29'd0, digit_count}, 32'd1);
`else
      check("bksp_cnt", {29'd0, digit_count}, 32'd2);
`endif
      release_key(8'h5A);
`ifdef PS2_BACKSPACE_EN
      check("bksp_value", {16'd0, value}, 32'h0007);
`else
      check("bksp_value", {16'd0, value}, 32'h0078);
`endif

      // Reset in the middle of a break sequence.
      release_key(8'h26);
      send(8'h14);
      send(8'hF0);
      #2;
      reset = 1'b0;
      #1;
      check_all_zero("midreset");
      @(negedge clk);
      reset = 1'b1;
      send(8'h45);
      check("post_reset_make", {31'd0, dato}, 32'd0);
      check_all_zero("post_reset");
      release_key(8'h45);
      check("post_reset_rel", {31'd0, dato}, 32'd1);
      check("post_reset_cnt", {29'd0, digit_count}, 32'd1);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter NUM_DIGITS, default 4: max decimal digits held in the entry accumulator (legal range 1..8).
REQ-002 Parameter CNT_W, default 3: width of digit_count; SHALL satisfy 2**CNT_W > NUM_DIGITS.
REQ-003 clk  in  1  single system clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 Dato_rx  in  8  scan code byte from PS/2 receiver.
REQ-006 rx_done  in  1  one-cycle strobe, Dato_rx valid this cycle.
REQ-007 ctrl  out  1  one-cycle pulse on Ctrl release.
REQ-008 ctrl_held  out  1  level, high while Ctrl is pressed.
REQ-009 enter  out  1  one-cycle pulse on Enter release.
REQ-010 dato  out  1  one-cycle pulse on digit-key release.
REQ-011 digit  out  4  BCD value of the last released digit; held between pulses.
REQ-012 value  out  4*NUM_DIGITS  BCD accumulator snapshot, latched on Enter.
REQ-013 value_valid  out  1  one-cycle pulse, coincident with enter.
REQ-014 digit_count  out  CNT_W  digits currently in accumulator.
REQ-015 overflow  out  1  sticky; set when a digit is dropped because the accumulator is full.

Function
REQ-016 Bytes SHALL be consumed only in cycles with rx_done=1; otherwise all state holds and all pulse outputs are 0.
REQ-017 FSM states IDLE, BRK, EXT, EXT_BRK; IDLE--F0-->BRK, IDLE--E0-->EXT, EXT--F0-->EXT_BRK, BRK/EXT_BRK--any byte-->IDLE, EXT--non-F0 byte-->IDLE, IDLE--other byte-->IDLE.
REQ-018 Key actions SHALL be taken only on the byte that exits BRK or EXT_BRK (key release); make codes trigger no pulse except ctrl_held.
REQ-019 Digit map: 45=0, 16=1, 1E=2, 26=3, 25=4, 2E=5, 36=6, 3D=7, 3E=8, 46=9; released in BRK only.
REQ-020 Ctrl = 14 (in BRK or EXT_BRK); Enter = 5A (in BRK or EXT_BRK, so keypad Enter counts).
REQ-021 ctrl_held SHALL set on make 14 (IDLE or EXT) and clear on release 14.
REQ-022 All pulses SHALL assert in the cycle after the rx_done cycle carrying the release byte (latency 1) and last exactly one cycle.
REQ-023 Digit release with digit_count<NUM_DIGITS: accumulator shifts left 4 bits, new digit in bits [3:0], digit_count+1.
REQ-024 Digit release with digit_count=NUM_DIGITS: accumulator unchanged, dato and digit still update, overflow set.
REQ-025 Enter release: value<=accumulator, value_valid=1, then accumulator, digit_count and overflow cleared; with zero digits value<=0 and value_valid still pulses.
REQ-026 Unmapped release byte SHALL return FSM to IDLE with no pulse and no state change.
REQ-027 Repeated F0 or E0 while in BRK/EXT_BRK SHALL be treated as an unmapped release byte.

Reset
REQ-028 reset low SHALL immediately force FSM=IDLE, accumulator=0, value=0, digit=0, digit_count=0, overflow=0, ctrl_held=0, all pulses 0, including mid-sequence (after F0/E0).
REQ-029 After reset deasserts, the first byte SHALL be decoded from IDLE.

Configuration
REQ-030 Macro PS2_BACKSPACE_EN: when defined, release of 66 (in BRK) with digit_count>0 shifts accumulator right 4 bits, zero-fills MSD, decrements digit_count and clears overflow; with digit_count=0 there is no effect; no pulse output in either case.
REQ-031 Without PS2_BACKSPACE_EN, 66 SHALL be an unmapped code (REQ-026).

Verification
REQ-032 Send 16,F0,16,1E,F0,1E,5A,F0,5A -> dato pulses twice (digit 1 then 2); value=0x0012, value_valid pulse, digit_count=0.
REQ-033 NUM_DIGITS=4: release 1,2,3,4,5 then Enter -> overflow=1 after fifth digit; value=0x1234; overflow 0 after Enter.
REQ-034 Send 14 -> ctrl_held=1; F0,14 -> ctrl pulse 1 cycle, ctrl_held=0; E0,F0,5A -> enter pulse.
REQ-035 Send F0, assert reset, deassert, send 45 -> no dato pulse; FSM in IDLE; all outputs 0.
REQ-036 PS2_BACKSPACE_EN defined: release 7,8 then 66 release then Enter -> value=0x0007; undefined -> value=0x0078.
REQ-037 Send F0,1C (unmapped) then F0,45 -> only one dato pulse, digit=0, digit_count=1.
